burst_enable_gen: RTL and testbench
===================================

# burst_enable_gen

Burst enable generator that drives the `EN` input of the digital-library `Counter`. On a start request it emits a programmed number of single-cycle enable strobes at a programmed spacing, so the downstream counter advances exactly `LEN` steps at a controlled rate. It signals completion with a one-cycle `DONE` pulse. The block is pure synchronous logic on one clock.

## Interface
Parameters:
- `DIV_WIDTH`, default 8: width of the strobe-spacing field.
- `LEN_WIDTH`, default 8: width of the burst-length field and remaining count.

Ports:
- `CLK`, input, 1 bit: single clock; all logic is on the rising edge.
- `RESET`, input, 1 bit: synchronous, active-high reset.
- `START`, input, 1 bit: burst request, sampled only in IDLE.
- `DIV`, input, `DIV_WIDTH` bits: strobe period minus 1, latched on an accepted `START`.
- `LEN`, input, `LEN_WIDTH` bits: number of strobes, latched on an accepted `START`.
- `ABORT`, input, 1 bit: terminates the burst with no `DONE`.
- `EN`, output, 1 bit: strobe to the downstream counter `EN`, one cycle wide.
- `BUSY`, output, 1 bit: high in RUN and DONE.
- `DONE`, output, 1 bit: one-cycle pulse on normal completion.
- `REMAIN`, output, `LEN_WIDTH` bits: strobes still to be issued.

## Operation
- **States:** IDLE, RUN, DONE (encoded in 2 bits).
- **Registers:** `div_q`, `div_cnt` (`DIV_WIDTH` bits each); `rem` (`LEN_WIDTH` bits).
- **IDLE:**
  - `START`=1 and `ABORT`=0: latch `div_q`←`DIV`, `div_cnt`←`DIV`, `rem`←`LEN`.
    - Next state is RUN if `LEN`≠0.
    - Next state is DONE if `LEN`=0; no strobes are issued.
  - `ABORT` wins over a simultaneous `START`: the block stays in IDLE.
- **RUN:**
  - `EN` = (state==RUN) && (`div_cnt`==0). `EN` is decoded from registers only, with no input-to-output path.
  - `div_cnt`≠0: decrement `div_cnt`.
  - `div_cnt`==0: reload `div_cnt`←`div_q` and decrement `rem`.
    - If `rem` was 1, next state is DONE.
  - `DIV`=0 gives a strobe every cycle.
  - Changes on `DIV` or `LEN` after acceptance have no effect.
- **DONE:** `DONE`=1 for exactly one cycle, then IDLE.
- **`START` handling:** `START` is ignored while `BUSY`=1 and is not queued.
- **`ABORT` in RUN:**
  - Next state is IDLE, `rem`←0, no `DONE`.
  - A strobe already decoded in the abort cycle is still issued.
- **`ABORT` in DONE:** ignored; the `DONE` pulse completes.
- **`RESET`:** highest priority, in any state.
  - State←IDLE, `div_cnt`←0, `div_q`←0, `rem`←0.
  - `RESET` mid-burst discards the burst with no `DONE`.
- **Reset values:** `EN`=0, `BUSY`=0, `DONE`=0, `REMAIN`=0.
- **`REMAIN`:** equals `rem`. After the k-th strobe it reads `LEN`−k. It never wraps below 0.

## Timing
- `START` is sampled at the edge ending cycle 0.
- Cycle 1: state RUN, `BUSY`=1, `REMAIN`=`LEN`.
- The k-th strobe (k=1..`LEN`) is high in cycle k·(`DIV`+1).
- `DONE` is high in cycle `LEN`·(`DIV`+1)+1, with `BUSY` still 1. State is IDLE from the next cycle.
- `LEN`=0: `DONE` and `BUSY` are high in cycle 1; IDLE in cycle 2.
- Earliest next accepted `START`: sampled in the first IDLE cycle, so back-to-back bursts have a one-cycle gap after `DONE`.
- `ABORT` sampled at the end of cycle c: `BUSY`=0 and `EN`=0 from cycle c+1.
- Maximum burst: (2^`LEN_WIDTH`−1) strobes at period 2^`DIV_WIDTH`. No counter overflows in that range.

## Structure
- **Shared package** (digital-library package): the state enum typedef (IDLE, RUN, DONE) and the default widths as constants.
- **One natural sub-module:** `strobe_prescaler`.
  - Reloadable down-counter holding `div_q`/`div_cnt`.
  - Inputs: `load`, `run`. Output: `tick`.
  - Instantiated once.
- The FSM and `rem` live in the top module.
- Expected size is about 150 lines of RTL.

## Test plan
- **Reset:** `RESET` high for 2 cycles, then low → `EN`=`BUSY`=`DONE`=0 and `REMAIN`=0. Then `START` with `DIV`=0, `LEN`=4 → `EN` high in cycles 1–4, `DONE` in cycle 5.
- **Spaced burst:** `DIV`=2, `LEN`=3, `START` at cycle 0 →
  - `EN` in cycles 3, 6 and 9;
  - `REMAIN` reads 3, 2, 1, 0;
  - `DONE` in cycle 10, IDLE in cycle 11;
  - downstream `Counter` advances from 0 to 3.
- **Zero length:** `LEN`=0 → no `EN`; `DONE`=1 and `BUSY`=1 in cycle 1.
- **Abort mid-burst:** `DIV`=1, `LEN`=5, `ABORT` in cycle 4 →
  - `EN` in cycles 2 and 4 only;
  - `BUSY`=0 in cycle 5, `REMAIN`=0, `DONE` never asserted.
- **Ignored inputs:** `START` pulsed in cycles 2 and 3 during an active burst, with `DIV`/`LEN` changed → strobe timing unchanged. `START` and `ABORT` together in IDLE → stays IDLE.
- **Reset mid-burst and boundary values:**
  - `RESET` in cycle 5 of a `LEN`=8 burst → IDLE in cycle 6, no `DONE`.
  - `DIV`=255, `LEN`=255 → strobes every 256 cycles, last in cycle 65280, `DONE` in cycle 65281.

Source files
------------

// File: rtl/burst_enable_gen_pkg.sv
// Shared types and default widths for the burst enable generator.
package burst_enable_gen_pkg;
   localparam int DIV_WIDTH_DEF = 8;
   localparam int LEN_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/burst_enable_gen_strobe_prescaler.sv
// Reloadable down-counter that sets the spacing between enable strobes.
module strobe_prescaler #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 run_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 tick_o
);
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q     <= '0;
         div_cnt_q <= '0;
      end else begin
         div_q     <= div_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   always_comb begin
      div_d     = div_q;
      div_cnt_d = div_cnt_q;
      if (load_i) begin
         div_d     = div_i;
         div_cnt_d = div_i;
      end else if (run_i) begin
         div_cnt_d = (div_cnt_q == '0) ? div_q : div_cnt_q - 1'b1;
      end
   end

   // Registered-only decode: no input reaches the strobe combinationally.
   assign tick_o = run_i && (div_cnt_q == '0);
endmodule

// File: rtl/burst_enable_gen.sv
// Emits LEN single-cycle enable strobes spaced DIV+1 cycles apart, then a DONE pulse.
//   state   | meaning
//   ST_IDLE | waiting for START
//   ST_RUN  | issuing strobes, rem counts what is left
//   ST_DONE | one-cycle completion pulse
module burst_enable_gen
   import burst_enable_gen_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEF,
   parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic [DIV_WIDTH-1:0] DIV,
   input  logic [LEN_WIDTH-1:0] LEN,
   input  logic                 ABORT,
   output logic                 EN,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [LEN_WIDTH-1:0] REMAIN
);
   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic                 load, run, tick;

   assign load = (state_q == ST_IDLE) && START && !ABORT;
   assign run  = (state_q == ST_RUN);

   strobe_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .load_i (load),
      .run_i  (run),
      .div_i  (DIV),
      .tick_o (tick)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               rem_d   = LEN;
               state_d = (LEN == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // The strobe decoded this cycle still goes out on abort.
            if (ABORT) begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end else if (tick) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == LEN_WIDTH'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign EN     = tick;
   assign BUSY   = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign DONE   = (state_q == ST_DONE);
   assign REMAIN = rem_q;
endmodule

// File: tb/tb_burst_enable_gen.sv
// Scoreboard bench for burst_enable_gen: per-cycle expected {EN,BUSY,DONE,REMAIN} from timing formulas.
module tb_burst_enable_gen;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic [7:0] DIV = '0;
   logic [7:0] LEN = '0;
   logic       ABORT = 1'b0;
   logic       EN, BUSY, DONE;
   logic [7:0] REMAIN;

   int n_checks = 0;
   int n_pass   = 0;
   int sb[$];

   burst_enable_gen dut (
      .CLK(CLK), .RESET(RESET), .START(START), .DIV(DIV), .LEN(LEN),
      .ABORT(ABORT), .EN(EN), .BUSY(BUSY), .DONE(DONE), .REMAIN(REMAIN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // Packed as {EN,BUSY,DONE,REMAIN[7:0]} for cycle c after START in cycle 0.
   function automatic int exp_out(int c, int d, int l, int a, int r);
      int period = d + 1;
      int endc   = (l == 0) ? 1 : l * period + 1;
      int cut    = 1 << 30;
      int en, remain;
      if (a >= 0 && a < endc) cut = a + 1;
      if (r >= 0 && r + 1 < cut) cut = r + 1;
      if (c >= cut || c > endc) return 0;
      if (c == endc) return (1 << 9) | (1 << 8);
      en     = (c % period == 0) ? 1 : 0;
      remain = l - (c - 1) / period;
      return (en << 10) | (1 << 9) | remain;
   endfunction

   function automatic int obs_out();
      return {21'd0, EN, BUSY, DONE, REMAIN};
   endfunction

   task automatic run_burst(input string name, input int d, input int l, input int a,
                            input int r, input int n, input bit poke, input int exp_strobes);
      int en_cnt = 0;
      @(posedge CLK); #1;
      START = 1'b1; DIV = 8'(d); LEN = 8'(l);
      ABORT = (a == 0); RESET = (r == 0);
      for (int c = 1; c <= n; c++) begin
         @(posedge CLK); #1;
         START = poke && (c == 2 || c == 3);
         if (poke && c == 2) begin
            DIV = 8'd7; LEN = 8'd9;
         end
         ABORT = (c == a);
         RESET = (c == r);
         sb.push_back(exp_out(c, d, l, a, r));
         check($sformatf("%s cyc%0d", name, c), obs_out(), sb.pop_front());
         en_cnt += int'(EN);
      end
      START = 1'b0; ABORT = 1'b0; RESET = 1'b0;
      check({name, " strobes"}, en_cnt, exp_strobes);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(posedge CLK); #1;
      sb.push_back(0);
      check("reset", obs_out(), sb.pop_front());

      run_burst("basic",      0,   4, -1, -1,     6, 1'b0,   4);
      run_burst("spaced",     2,   3, -1, -1,    11, 1'b0,   3);
      run_burst("zero_len",   3,   0, -1, -1,     3, 1'b0,   0);
      run_burst("abort",      1,   5,  4, -1,     8, 1'b0,   2);
      run_burst("ignored",    2,   3, -1, -1,    11, 1'b1,   3);
      run_burst("start_abrt", 0,   4,  0, -1,     3, 1'b0,   0);
      run_burst("abort_done", 0,   2,  3, -1,     5, 1'b0,   2);
      run_burst("reset_mid",  0,   8, -1,  5,     8, 1'b0,   5);
      run_burst("back2back",  1,   2, -1, -1,     5, 1'b0,   2);
      run_burst("max",      255, 255, -1, -1, 65282, 1'b0, 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
